// File: rtl/fwd_pkg.sv
// Shared widths, bypass-select encodings and the pipeline tracking-entry type
// for the forwarding/hazard controller.
package fwd_pkg;

  localparam int unsigned REG_W = 3;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] FWD_RF    = 2'b00;
  localparam logic [SEL_W-1:0] FWD_EXMEM = 2'b01;
  localparam logic [SEL_W-1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             reg_write;
    logic             mem_read;
  } pipe_entry_t;

  // True when the tracked producer writes the register read as src.
  function automatic logic tag_match(pipe_entry_t e, logic [REG_W-1:0] src, logic zero_hw);
    return e.valid && e.reg_write && (e.dest == src) && !(zero_hw && (src == '0));
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_stage_tag_reg.sv
// One pipeline tracking entry: loads the upstream entry every cycle, or an
// invalid entry when a bubble is injected.
module stage_tag_reg
  import fwd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble_i,
  input  pipe_entry_t d_i,
  output pipe_entry_t q_o
);

  pipe_entry_t entry_q;
  pipe_entry_t entry_d;

  always_comb begin
    entry_d = d_i;
    if (bubble_i) begin
      entry_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for a 5-stage pipeline: tracks
// in-flight destinations and registers the EX-stage bypass selects.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_W          = 3,
  parameter bit          ZERO_HARDWIRED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_dest_is_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             fwd_reg_src,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic             ex_bubble
);

  import fwd_pkg::*;

  pipe_entry_t id_entry;
  pipe_entry_t ex_q;
  pipe_entry_t mem_q;
  pipe_entry_t unused_wb_q;

  logic       load_ex;
  logic       ex_a, ex_b, mem_a, mem_b;
  logic       fwd_reg_src_q, fwd_reg_src_d;
  logic [1:0] fwd_a_sel_q, fwd_a_sel_d;
  logic [1:0] fwd_b_sel_q, fwd_b_sel_d;
  logic       ex_bubble_q, ex_bubble_d;

  always_comb begin
    id_entry           = '0;
    id_entry.valid     = 1'b1;
    id_entry.dest      = id_dest_is_rd ? id_rd : id_rt;
    id_entry.reg_write = id_reg_write;
    id_entry.mem_read  = id_mem_read;
  end

  // Source matches against the EX and MEM producers; unused sources never match.
  always_comb begin
    ex_a  = id_uses_rs && tag_match(ex_q,  id_rs, ZERO_HARDWIRED);
    ex_b  = id_uses_rt && tag_match(ex_q,  id_rt, ZERO_HARDWIRED);
    mem_a = id_uses_rs && tag_match(mem_q, id_rs, ZERO_HARDWIRED);
    mem_b = id_uses_rt && tag_match(mem_q, id_rt, ZERO_HARDWIRED);
  end

  always_comb begin
    stall   = id_valid && ex_q.mem_read && (ex_a || ex_b) && !flush;
    load_ex = id_valid && !stall && !flush;
  end

  // Load data is captured into the EX/MEM bypass after the memory read, so a
  // load sitting in MEM is forwarded through the EX/MEM path.
  always_comb begin
    fwd_reg_src_d = 1'b0;
    fwd_a_sel_d   = FWD_RF;
    fwd_b_sel_d   = FWD_RF;
    ex_bubble_d   = stall || flush;
    if (load_ex) begin
      fwd_reg_src_d = id_dest_is_rd;
      if (ex_a) begin
        fwd_a_sel_d = FWD_EXMEM;
      end else if (mem_a) begin
        fwd_a_sel_d = mem_q.mem_read ? FWD_EXMEM : FWD_MEMWB;
      end
      if (ex_b) begin
        fwd_b_sel_d = FWD_EXMEM;
      end else if (mem_b) begin
        fwd_b_sel_d = mem_q.mem_read ? FWD_EXMEM : FWD_MEMWB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_reg_src_q <= 1'b0;
      fwd_a_sel_q   <= FWD_RF;
      fwd_b_sel_q   <= FWD_RF;
      ex_bubble_q   <= 1'b0;
    end else begin
      fwd_reg_src_q <= fwd_reg_src_d;
      fwd_a_sel_q   <= fwd_a_sel_d;
      fwd_b_sel_q   <= fwd_b_sel_d;
      ex_bubble_q   <= ex_bubble_d;
    end
  end

  assign fwd_reg_src = fwd_reg_src_q;
  assign fwd_a_sel   = fwd_a_sel_q;
  assign fwd_b_sel   = fwd_b_sel_q;
  assign ex_bubble   = ex_bubble_q;

  stage_tag_reg u_ex (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (!load_ex),
    .d_i      (id_entry),
    .q_o      (ex_q)
  );

  stage_tag_reg u_mem (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (1'b0),
    .d_i      (ex_q),
    .q_o      (mem_q)
  );

  // WB is tracked for completeness; the write-before-read register file needs no bypass from it.
  stage_tag_reg u_wb (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (1'b0),
    .d_i      (mem_q),
    .q_o      (unused_wb_q)
  );

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed vector bench for fwd_hazard_ctrl: one table row per ID cycle,
// plus a hand-driven back-to-back load sequence.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_rs, id_rt, id_rd;
  logic       id_uses_rs, id_uses_rt, id_dest_is_rd, id_reg_write, id_mem_read;
  logic       flush;
  logic       fwd_reg_src;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall, ex_bubble;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_dest_is_rd (id_dest_is_rd),
    .id_reg_write  (id_reg_write),
    .id_mem_read   (id_mem_read),
    .flush         (flush),
    .fwd_reg_src   (fwd_reg_src),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .stall         (stall),
    .ex_bubble     (ex_bubble)
  );

  typedef struct {
    bit       rst;
    bit       valid;
    bit [2:0] rs, rt, rd;
    bit       urs, urt, drd, rw, mr;
    bit       fl;
    bit       e_stall;
    bit       e_src;
    bit [1:0] e_a, e_b;
    bit       e_bub;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t nop();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t r_op(bit [2:0] rd, bit [2:0] rs, bit [2:0] rt);
    vec_t v = nop();
    v.valid = 1'b1; v.rs = rs; v.rt = rt; v.rd = rd;
    v.urs = 1'b1; v.urt = 1'b1; v.drd = 1'b1; v.rw = 1'b1;
    return v;
  endfunction

  function automatic vec_t i_op(bit [2:0] rt, bit [2:0] rs, bit ld);
    vec_t v = nop();
    v.valid = 1'b1; v.rs = rs; v.rt = rt; v.rd = 3'd0;
    v.urs = 1'b1; v.urt = 1'b0; v.drd = 1'b0; v.rw = 1'b1; v.mr = ld;
    return v;
  endfunction

  task automatic add(input vec_t v, input bit r, input bit fl, input bit es, input bit esrc,
                     input bit [1:0] ea, input bit [1:0] eb, input bit ebub);
    v.rst = r; v.fl = fl; v.e_stall = es; v.e_src = esrc;
    v.e_a = ea; v.e_b = eb; v.e_bub = ebub;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; id_valid = v.valid; id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    id_uses_rs = v.urs; id_uses_rt = v.urt; id_dest_is_rd = v.drd;
    id_reg_write = v.rw; id_mem_read = v.mr; flush = v.fl;
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s row %0d: got %0d, expected %0d", name, idx, act, exp);
  endtask

  initial begin
    int scnt;

    // Sequence rows: reset, EX/MEM forwarding, double match, load-use,
    // zero register, flush vs load-use, mid-stream reset.
    add(nop(),              1, 0, 0, 0, 2'b00, 2'b00, 0);  // 0
    add(nop(),              1, 0, 0, 0, 2'b00, 2'b00, 0);  // 1
    add(r_op(3, 1, 2),      0, 0, 0, 1, 2'b00, 2'b00, 0);  // 2 producer r3
    add(r_op(5, 3, 4),      0, 0, 0, 1, 2'b01, 2'b00, 0);  // 3 EX->EX
    add(i_op(5, 0, 0),      0, 0, 0, 0, 2'b00, 2'b00, 0);  // 4 I-type r5
    add(r_op(6, 1, 1),      0, 0, 0, 1, 2'b00, 2'b00, 0);  // 5 independent
    add(r_op(7, 1, 5),      0, 0, 0, 1, 2'b00, 2'b10, 0);  // 6 MEM->EX on rt
    add(i_op(2, 1, 0),      0, 0, 0, 0, 2'b00, 2'b00, 0);  // 7 r2 distance 2
    add(i_op(2, 1, 0),      0, 0, 0, 0, 2'b00, 2'b00, 0);  // 8 r2 distance 1
    add(r_op(1, 2, 0),      0, 0, 0, 1, 2'b01, 2'b00, 0);  // 9 double match
    add(i_op(4, 0, 1),      0, 0, 0, 0, 2'b00, 2'b00, 0);  // 10 load r4
    add(r_op(5, 4, 1),      0, 0, 1, 0, 2'b00, 2'b00, 1);  // 11 load-use stall
    add(r_op(5, 4, 1),      0, 0, 0, 1, 2'b01, 2'b00, 0);  // 12 replay
    add(r_op(0, 1, 1),      0, 0, 0, 1, 2'b00, 2'b00, 0);  // 13 writes r0
    add(r_op(6, 0, 0),      0, 0, 0, 1, 2'b00, 2'b00, 0);  // 14 reads r0
    add(i_op(0, 1, 1),      0, 0, 0, 0, 2'b00, 2'b00, 0);  // 15 load r0
    add(r_op(7, 0, 2),      0, 0, 0, 1, 2'b00, 2'b00, 0);  // 16 no stall on r0
    add(i_op(3, 1, 1),      0, 0, 0, 0, 2'b00, 2'b00, 0);  // 17 load r3
    add(r_op(4, 3, 1),      0, 1, 0, 0, 2'b00, 2'b00, 1);  // 18 flush wins
    add(nop(),              0, 0, 0, 0, 2'b00, 2'b00, 0);  // 19 idle
    add(r_op(2, 1, 1),      0, 0, 0, 1, 2'b00, 2'b00, 0);  // 20 producer r2
    add(r_op(5, 2, 2),      1, 0, 0, 0, 2'b00, 2'b00, 0);  // 21 reset mid-stream
    add(r_op(5, 2, 2),      1, 0, 0, 0, 2'b00, 2'b00, 0);  // 22
    add(r_op(5, 2, 2),      0, 0, 0, 1, 2'b00, 2'b00, 0);  // 23 first after reset

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      #1;
      chk("stall", i, int'(stall), int'(tbl[i].e_stall));
      @(posedge clk);
      #1;
      chk("fwd_reg_src", i, int'(fwd_reg_src), int'(tbl[i].e_src));
      chk("fwd_a_sel",   i, int'(fwd_a_sel),   int'(tbl[i].e_a));
      chk("fwd_b_sel",   i, int'(fwd_b_sel),   int'(tbl[i].e_b));
      chk("ex_bubble",   i, int'(ex_bubble),   int'(tbl[i].e_bub));
      @(negedge clk);
    end

    // Back-to-back loads into r4, then a consumer of r4 on both sources.
    drive(i_op(4, 1, 1));
    @(negedge clk);
    drive(i_op(4, 1, 1));
    #1;
    chk("b2b_second_load_stall", 100, int'(stall), 0);
    @(negedge clk);
    drive(r_op(6, 4, 4));
    scnt = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (!stall) break;
      scnt++;
      @(posedge clk);
      #1;
      if (k == 0) chk("b2b_bubble", 101, int'(ex_bubble), 1);
      @(negedge clk);
    end
    chk("b2b_stall_cycles", 102, scnt, 1);
    @(posedge clk);
    #1;
    chk("b2b_fwd_a_sel", 103, int'(fwd_a_sel), 1);
    chk("b2b_fwd_b_sel", 104, int'(fwd_b_sel), 1);
    chk("b2b_ex_bubble", 105, int'(ex_bubble), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
